// File: rtl/sorter_pkg.sv
// Shared types and helpers for the bit-sorter datapath family.
package sorter_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_t;

    localparam logic MODE_ZEROS_FIRST = 1'b0;
    localparam logic MODE_ONES_FIRST  = 1'b1;

    // Ceiling log2 usable in parameter expressions; sorterClog2(1) is 0.
    function automatic int sorterClog2(input int value);
        int result;
        result = 0;
        for (int w = 1; w < value; w = w * 2) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/bit_popcount.sv
// Combinational ones counter; result is wide enough to hold WIDTH itself.
module bit_popcount
    import sorter_pkg::*;
#(
    parameter int WIDTH = 8,
    localparam int CW   = sorterClog2(WIDTH + 1)
) (
    input  logic [WIDTH-1:0] data_i,
    output logic [CW-1:0]    count_o
);

    // Written as a linear sum; synthesis rebalances it into an adder tree.
    always_comb begin
        count_o = '0;
        for (int i = 0; i < WIDTH; i++) begin
            count_o = count_o + CW'(data_i[i]);
        end
    end

endmodule

// File: rtl/bit_sorter_stream.sv
// Accepts a word, counts its ones, and streams its bits back sorted
// (zeros-first or ones-first) one bit per beat with a one-word pending buffer.
module bit_sorter_stream
    import sorter_pkg::*;
#(
    parameter int WIDTH = 8,
    localparam int CW   = sorterClog2(WIDTH + 1),
    localparam int IW   = sorterClog2(WIDTH)
) (
    input  logic             ck,
    input  logic             reset,
    input  logic             clr,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_mode,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             out_bit,
    output logic             out_valid,
    output logic             out_last,
    input  logic             out_ready,
    output logic [CW-1:0]    ones_count
);

    localparam logic [IW-1:0] LAST_IDX = IW'(WIDTH - 1);

    state_t          state_q;
    logic            pendFull_q;
    logic            pendMode_q;
    logic [CW-1:0]   pendCnt_q;
    logic            streamMode_q;
    logic [CW-1:0]   ones_q;
    logic [IW-1:0]   idx_q;
    logic            outValid_q;
    logic            outBit_q;
    logic            outLast_q;

    logic [CW-1:0]   inCnt_d;
    logic [IW-1:0]   nextIdx_d;
    logic            accept;
    logic            beat;

    bit_popcount #(.WIDTH(WIDTH)) uPopcount (
        .data_i  (in_data),
        .count_o (inCnt_d)
    );

    // Sorted bit at beat j, compared one bit wider than the count so
    // WIDTH - ones never wraps.
    function automatic logic bitAt(input logic [IW-1:0] j,
                                   input logic [CW-1:0] ones,
                                   input logic          mode);
        logic [CW:0] jx;
        logic [CW:0] ox;
        logic [CW:0] limit;
        jx    = (CW+1)'(j);
        ox    = (CW+1)'(ones);
        limit = (CW+1)'(WIDTH) - ox;
        if (mode == MODE_ONES_FIRST) begin
            return jx < ox;
        end
        return jx >= limit;
    endfunction

    assign accept    = in_valid && !pendFull_q;
    assign beat      = outValid_q && out_ready;
    assign nextIdx_d = idx_q + IW'(1);

    assign in_ready   = !pendFull_q;
    assign out_bit    = outBit_q;
    assign out_valid  = outValid_q;
    assign out_last   = outLast_q;
    assign ones_count = ones_q;

    always_ff @(posedge ck or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            pendFull_q   <= 1'b0;
            pendMode_q   <= 1'b0;
            pendCnt_q    <= '0;
            streamMode_q <= 1'b0;
            ones_q       <= '0;
            idx_q        <= '0;
            outValid_q   <= 1'b0;
            outBit_q     <= 1'b0;
            outLast_q    <= 1'b0;
        end else if (clr) begin
            state_q    <= IDLE;
            pendFull_q <= 1'b0;
            idx_q      <= '0;
            outValid_q <= 1'b0;
            outBit_q   <= 1'b0;
            outLast_q  <= 1'b0;
        end else begin
            // Accept and drain never collide: accept needs the buffer empty.
            if (accept) begin
                pendMode_q <= in_mode;
                pendCnt_q  <= inCnt_d;
                pendFull_q <= 1'b1;
            end

            case (state_q)
                IDLE: begin
                    if (pendFull_q) begin
                        ones_q       <= pendCnt_q;
                        streamMode_q <= pendMode_q;
                        idx_q        <= '0;
                        pendFull_q   <= 1'b0;
                        state_q      <= STREAM;
                        outValid_q   <= 1'b1;
                        outBit_q     <= bitAt('0, pendCnt_q, pendMode_q);
                        outLast_q    <= 1'b0;
                    end
                end

                STREAM: begin
                    if (beat) begin
                        if (idx_q == LAST_IDX) begin
                            if (pendFull_q) begin
                                ones_q       <= pendCnt_q;
                                streamMode_q <= pendMode_q;
                                idx_q        <= '0;
                                pendFull_q   <= 1'b0;
                                outBit_q     <= bitAt('0, pendCnt_q, pendMode_q);
                                outLast_q    <= 1'b0;
                            end else begin
                                state_q    <= IDLE;
                                idx_q      <= '0;
                                outValid_q <= 1'b0;
                                outBit_q   <= 1'b0;
                                outLast_q  <= 1'b0;
                            end
                        end else begin
                            idx_q     <= nextIdx_d;
                            outBit_q  <= bitAt(nextIdx_d, ones_q, streamMode_q);
                            outLast_q <= (nextIdx_d == LAST_IDX);
                        end
                    end
                end

                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule
